// File: rtl/idma_desc64_r_unpack.sv
// -----------------------------------------------------------------------------
// idma_desc64_r_unpack
//   Descriptor read-response stage of the desc64 frontend. Collects AXI R beats
//   of descriptor fetches into full descriptors, presents them downstream
//   through a single output register, returns the next pointer to the
//   AR-generation stage, and discards speculatively fetched descriptors the
//   AR-generation stage asks to flush.
//
//   Optional feature macro: IDMA_DESC64_R_RESP_CHECK_EN
//     defined   : R error responses and r_last_i mismatches pulse err_o, and a
//                 descriptor with any erroneous beat is dropped.
//     undefined : r_resp_i / r_last_i are ignored and err_o is tied low.
// -----------------------------------------------------------------------------
module idma_desc64_r_unpack #(
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned DescWidth    = 256,
    parameter int unsigned NextWordIdx  = 1,
    parameter int unsigned NSpeculation = 4,
    localparam int unsigned FlushWidth  = $clog2(NSpeculation + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // AXI R channel (descriptor fetches only)
    input  logic [DataWidth-1:0]  r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_last_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    // flush request from the AR-generation stage
    input  logic [FlushWidth-1:0] n_flush_i,
    input  logic                  n_flush_valid_i,
    // assembled descriptor
    output logic [DescWidth-1:0]  desc_o,
    output logic                  desc_valid_o,
    input  logic                  desc_ready_i,
    // next pointer back to the AR-generation stage
    output logic [AddrWidth-1:0]  next_addr_o,
    output logic                  next_addr_valid_o,
    // status
    output logic                  err_o,
    output logic                  busy_o
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int unsigned Beats    = DescWidth / DataWidth;
    localparam int unsigned BeatCntW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned CntW     = FlushWidth + 1;
    localparam int unsigned SumW     = CntW + 1;

    localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(Beats - 1);
    localparam logic [CntW-1:0]     FlushMax = {CntW{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [BeatCntW-1:0]  beat_cnt_q, beat_cnt_d;
    logic                 hold_q, hold_d;
    logic [CntW-1:0]      flush_cnt_q, flush_cnt_d;
    logic [DescWidth-1:0] asm_q, asm_d;    // assembly buffer, filled beat by beat
    logic [DescWidth-1:0] desc_q, desc_d;  // output register, stable while valid

    // -------------------------------------------------------------------------
    // Handshake and flush decode
    // -------------------------------------------------------------------------
    logic                  is_last_beat;
    logic                  r_hs;
    logic                  last_hs;
    logic [FlushWidth-1:0] flush_req;
    logic [SumW-1:0]       flush_sum;
    logic [CntW-1:0]       flush_sat;
    logic                  flush_drop;
    logic                  err_drop;
    logic                  present;

    assign is_last_beat = (beat_cnt_q == LastBeat);

    // The final beat stalls while a descriptor is held and nothing is pending
    // flush; this also guarantees a valid-low gap between descriptors.
    assign r_ready_o = !rst_i && !(hold_q && is_last_beat && (flush_cnt_q == '0));

    assign r_hs    = r_valid_i && r_ready_o;
    assign last_hs = r_hs && is_last_beat;

    // Pending-flush arithmetic: accumulate the request (saturating), then let a
    // completing descriptor consume one pending flush, including one requested
    // in this very cycle.
    assign flush_req  = n_flush_valid_i ? n_flush_i : '0;
    assign flush_sum  = SumW'(flush_cnt_q) + SumW'(flush_req);
    assign flush_sat  = flush_sum[CntW] ? FlushMax : flush_sum[CntW-1:0];
    assign flush_drop = last_hs && (flush_sat != '0);

    assign present = last_hs && !flush_drop && !err_drop;

    // -------------------------------------------------------------------------
    // Optional response checking
    // -------------------------------------------------------------------------
`ifdef IDMA_DESC64_R_RESP_CHECK_EN
    logic err_flag_q, err_flag_d;  // sticky: current descriptor saw an error beat
    logic err_q, err_d;
    logic unused_resp;

    assign unused_resp = r_resp_i[0];

    // Error flag tracking and one-cycle error pulse generation
    always_comb begin
        err_flag_d = err_flag_q;
        err_d      = 1'b0;
        if (r_hs) begin
            if (r_resp_i[1]) begin
                err_flag_d = 1'b1;
            end
            err_d = r_resp_i[1] || (r_last_i != is_last_beat);
            if (is_last_beat) begin
                err_flag_d = 1'b0;
            end
        end
    end

    // Error state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
        end
    end

    assign err_drop = err_flag_q || r_resp_i[1];
    assign err_o    = err_q;
`else
    logic unused_resp;

    assign unused_resp = ^{r_resp_i, r_last_i};
    assign err_drop    = 1'b0;
    assign err_o       = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic: beat counter, assembly, output register, flush counter
    // -------------------------------------------------------------------------
    // NOTE: every _d gets its hold value before any condition, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        hold_d      = hold_q;
        asm_d       = asm_q;
        desc_d      = desc_q;
        flush_cnt_d = flush_sat - CntW'(flush_drop);

        if (hold_q && desc_ready_i) begin
            hold_d = 1'b0;
        end

        if (r_hs) begin
            asm_d[beat_cnt_q*DataWidth +: DataWidth] = r_data_i;
            beat_cnt_d = is_last_beat ? '0 : beat_cnt_q + 1'b1;
        end

        // Only a descriptor that survives flush and error checks reaches the
        // output register; dropped ones leave desc_q and hold_q untouched.
        if (present) begin
            desc_d = asm_d;
            hold_d = 1'b1;
        end
    end

    // State registers
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q  <= '0;
            hold_q      <= 1'b0;
            flush_cnt_q <= '0;
            // NOTE: the data registers are reset too, so desc_o reads zero after
            // reset and a partial descriptor cannot leak into the next one.
            asm_q       <= '0;
            desc_q      <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            hold_q      <= hold_d;
            flush_cnt_q <= flush_cnt_d;
            asm_q       <= asm_d;
            desc_q      <= desc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign desc_o            = desc_q;
    assign desc_valid_o      = hold_q;
    assign next_addr_o       = desc_q[AddrWidth*NextWordIdx +: AddrWidth];
    assign next_addr_valid_o = hold_q;
    assign busy_o            = (beat_cnt_q != '0) || hold_q || (flush_cnt_q != '0);

`ifndef SYNTHESIS
    // A new flush request is only legal once all earlier flushes are consumed.
    flush_while_pending : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (n_flush_valid_i && (n_flush_i != '0)) |-> (flush_cnt_q == '0)
    );
`endif

endmodule

// File: tb/tb_idma_desc64_r_unpack.sv
// -----------------------------------------------------------------------------
// tb_idma_desc64_r_unpack
//   Directed bench for idma_desc64_r_unpack (default parameters). A behavioural
//   model (beat index, pending flushes, held descriptor) is updated every cycle
//   and compared against the DUT; directed literal checks pin the model.
//   Honours IDMA_DESC64_R_RESP_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_idma_desc64_r_unpack;

    localparam int FW = 3;  // $clog2(4+1)

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [63:0]   r_data_i = '0;
    logic [1:0]    r_resp_i = '0;
    logic          r_last_i = 1'b0;
    logic          r_valid_i = 1'b0;
    logic          r_ready_o;
    logic [FW-1:0] n_flush_i = '0;
    logic          n_flush_valid_i = 1'b0;
    logic [255:0]  desc_o;
    logic          desc_valid_o;
    logic          desc_ready_i = 1'b0;
    logic [63:0]   next_addr_o;
    logic          next_addr_valid_o;
    logic          err_o;
    logic          busy_o;

    idma_desc64_r_unpack dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .r_data_i          (r_data_i),
        .r_resp_i          (r_resp_i),
        .r_last_i          (r_last_i),
        .r_valid_i         (r_valid_i),
        .r_ready_o         (r_ready_o),
        .n_flush_i         (n_flush_i),
        .n_flush_valid_i   (n_flush_valid_i),
        .desc_o            (desc_o),
        .desc_valid_o      (desc_valid_o),
        .desc_ready_i      (desc_ready_i),
        .next_addr_o       (next_addr_o),
        .next_addr_valid_o (next_addr_valid_o),
        .err_o             (err_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [63:0]  m_words [4];
    int           m_beat  = 0;
    int           m_flush = 0;
    bit           m_held  = 0;
    logic [255:0] m_out   = '0;
    bit           m_eflag = 0;
    bit           m_err   = 0;
    bit           m_known = 0;

    logic [255:0] delivered [$];
    int           err_pulses   = 0;
    int           stall_cycles = 0;

    // Compare outputs against the model mid-cycle, then advance the model by
    // the edge that follows.
    always @(negedge clk_i) begin
        bit exp_ready;
        exp_ready = !rst_i && !(m_held && m_beat == 3 && m_flush == 0);
        if (m_known) begin
            check("r_ready_o",         256'(r_ready_o),         256'(exp_ready));
            check("desc_valid_o",      256'(desc_valid_o),      256'(m_held));
            check("next_addr_valid_o", 256'(next_addr_valid_o), 256'(m_held));
            check("desc_o",            desc_o,                  m_out);
            check("next_addr_o",       256'(next_addr_o),       256'(m_out[127:64]));
            check("busy_o",            256'(busy_o),
                  256'(m_beat != 0 || m_held || m_flush != 0));
            check("err_o",             256'(err_o),             256'(m_err));
            if (!rst_i && desc_valid_o && desc_ready_i) delivered.push_back(desc_o);
            if (err_o) err_pulses++;
            if (!rst_i && r_valid_i && !r_ready_o) stall_cycles++;
        end

        if (rst_i) begin
            m_beat = 0; m_flush = 0; m_held = 0; m_out = '0;
            m_eflag = 0; m_err = 0; m_known = 1;
        end else begin
            int tot;
            bit err_now;
            tot = m_flush + (n_flush_valid_i ? int'(n_flush_i) : 0);
            if (tot > 15) tot = 15;
            err_now = 0;
            if (m_held && desc_ready_i) m_held = 0;
            if (r_valid_i && exp_ready) begin
                m_words[m_beat] = r_data_i;
`ifdef IDMA_DESC64_R_RESP_CHECK_EN
                if (r_resp_i[1]) begin
                    err_now = 1;
                    m_eflag = 1;
                end
                if (r_last_i != (m_beat == 3)) err_now = 1;
`endif
                if (m_beat == 3) begin
                    if (tot > 0) tot--;
                    else if (!m_eflag) begin
                        m_held = 1;
                        m_out  = {m_words[3], m_words[2], m_words[1], m_words[0]};
                    end
                    m_eflag = 0;
                end
                m_beat = (m_beat + 1) % 4;
            end
            m_flush = tot;
            m_err   = err_now;
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic send_beat(input logic [63:0] d, input logic last, input logic [1:0] resp);
        bit hs;
        r_valid_i = 1'b1;
        r_data_i  = d;
        r_last_i  = last;
        r_resp_i  = resp;
        hs = 0;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk_i);
            hs = r_ready_o;
            @(posedge clk_i);
            #1;
        end
        if (!hs) check("beat handshake timeout", 256'(0), 256'(1));
        r_valid_i = 1'b0;
        r_resp_i  = 2'b00;
        r_last_i  = 1'b0;
    endtask

    task automatic send_desc(input logic [63:0] w0, input logic [63:0] w1,
                             input logic [63:0] w2, input logic [63:0] w3,
                             input int err_beat);
        logic [63:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < 4; k++)
            send_beat(w[k], k == 3, (k == err_beat) ? 2'b10 : 2'b00);
    endtask

    task automatic wait_delivered(input int n);
        for (int c = 0; c < 200; c++) begin
            if (delivered.size() >= n) break;
            @(posedge clk_i);
            #2;
        end
        if (delivered.size() < n) check("delivery timeout", 256'(delivered.size()), 256'(n));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- tests
    initial begin
        int base;

        // Reset
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check("reset desc_o",    desc_o,               256'(0));
        check("reset busy_o",    256'(busy_o),         256'(0));
        check("reset r_ready_o", 256'(r_ready_o),      256'(1));

        // 1: single descriptor, ready held high, 1-cycle latency
        desc_ready_i = 1'b1;
        base = delivered.size();
        send_desc(64'hA0, 64'h1000, 64'hB0, 64'hC0, -1);
        check("t1 valid one cycle after last beat", 256'(desc_valid_o), 256'(1));
        check("t1 next_addr_o", 256'(next_addr_o), 256'(64'h1000));
        wait_delivered(base + 1);
        check("t1 desc", delivered[base], {64'hC0, 64'hB0, 64'h1000, 64'hA0});

        // 2: back-to-back descriptors with downstream stalled for 5 cycles
        wait_cycles(2);
        desc_ready_i = 1'b0;
        base = delivered.size();
        stall_cycles = 0;
        fork
            begin
                send_desc(64'h11, 64'h2000, 64'h13, 64'h14, -1);
                send_desc(64'h21, 64'h3000, 64'h23, 64'h24, -1);
            end
            begin
                for (int c = 0; c < 100 && !desc_valid_o; c++) begin
                    @(posedge clk_i);
                    #2;
                end
                repeat (5) @(posedge clk_i);
                #1 desc_ready_i = 1'b1;
                wait_delivered(base + 1);
                check("t2 valid gap after handshake", 256'(next_addr_valid_o), 256'(0));
            end
        join
        wait_delivered(base + 2);
        check("t2 final beat stalled", 256'(stall_cycles != 0), 256'(1));
        check("t2 desc 1", delivered[base],     {64'h14, 64'h13, 64'h2000, 64'h11});
        check("t2 desc 2", delivered[base + 1], {64'h24, 64'h23, 64'h3000, 64'h21});

        // 3: flush 2 while holding a descriptor
        wait_cycles(2);
        desc_ready_i = 1'b0;
        base = delivered.size();
        send_desc(64'h31, 64'h4000, 64'h33, 64'h34, -1);
        wait_cycles(1);
        n_flush_valid_i = 1'b1;
        n_flush_i       = 3'd2;
        @(posedge clk_i);
        #1 n_flush_valid_i = 1'b0;
        n_flush_i = '0;
        send_desc(64'h41, 64'h5000, 64'h43, 64'h44, -1);
        send_desc(64'h51, 64'h6000, 64'h53, 64'h54, -1);
        #1;
        check("t3 held desc unchanged", desc_o, {64'h34, 64'h33, 64'h4000, 64'h31});
        check("t3 nothing delivered yet", 256'(delivered.size()), 256'(base));
        desc_ready_i = 1'b1;
        send_desc(64'h61, 64'h7000, 64'h63, 64'h64, -1);
        wait_delivered(base + 2);
        wait_cycles(2);
        check("t3 delivered count", 256'(delivered.size()), 256'(base + 2));
        check("t3 held desc delivered", delivered[base], {64'h34, 64'h33, 64'h4000, 64'h31});
        check("t3 third fetched desc",  delivered[base + 1], {64'h64, 64'h63, 64'h7000, 64'h61});
        check("t3 busy low", 256'(busy_o), 256'(0));

        // 4: flush 1 coinciding with a last-beat handshake
        base = delivered.size();
        send_beat(64'h71, 1'b0, 2'b00);
        send_beat(64'h8000, 1'b0, 2'b00);
        send_beat(64'h73, 1'b0, 2'b00);
        n_flush_valid_i = 1'b1;
        n_flush_i       = 3'd1;
        send_beat(64'h74, 1'b1, 2'b00);
        n_flush_valid_i = 1'b0;
        n_flush_i = '0;
        #1;
        check("t4 dropped not valid", 256'(desc_valid_o), 256'(0));
        check("t4 flush consumed", 256'(busy_o), 256'(0));
        send_desc(64'h81, 64'h9000, 64'h83, 64'h84, -1);
        wait_delivered(base + 1);
        wait_cycles(2);
        check("t4 delivered count", 256'(delivered.size()), 256'(base + 1));
        check("t4 next desc", delivered[base], {64'h84, 64'h83, 64'h9000, 64'h81});

        // 5: reset in the middle of a descriptor
        send_beat(64'hE1, 1'b0, 2'b00);
        send_beat(64'hE2, 1'b0, 2'b00);
        send_beat(64'hE3, 1'b0, 2'b00);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("t5 desc_o zero",    desc_o,                 256'(0));
        check("t5 next_addr zero", 256'(next_addr_o),      256'(0));
        check("t5 valid zero",     256'(desc_valid_o),     256'(0));
        check("t5 busy zero",      256'(busy_o),           256'(0));
        check("t5 ready zero",     256'(r_ready_o),        256'(0));
        rst_i = 1'b0;
        base = delivered.size();
        send_desc(64'h91, 64'hA000, 64'h93, 64'h94, -1);
        wait_delivered(base + 1);
        check("t5 fresh desc", delivered[base], {64'h94, 64'h93, 64'hA000, 64'h91});

        // 6: error response on beat 1
        wait_cycles(2);
        base = delivered.size();
        err_pulses = 0;
        send_desc(64'hAA1, 64'hB000, 64'hAA3, 64'hAA4, 1);
        wait_cycles(4);
`ifdef IDMA_DESC64_R_RESP_CHECK_EN
        check("t6 err pulses", 256'(err_pulses), 256'(1));
        check("t6 desc dropped", 256'(delivered.size()), 256'(base));
`else
        check("t6 err pulses", 256'(err_pulses), 256'(0));
        check("t6 desc presented", 256'(delivered.size()), 256'(base + 1));
        if (delivered.size() > base)
            check("t6 desc", delivered[base], {64'hAA4, 64'hAA3, 64'hB000, 64'hAA1});
`endif
        check("t6 busy low", 256'(busy_o), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
